io_request_encoder: RTL and testbench
=====================================

Name: io_request_encoder

Overview:
Reverse direction of the I/O port decoder. Collects request pulses from up to 16 input devices and latches each one as pending. Arbitrates among pending requests round-robin and presents the winner to the Nibbler CPU as a 4-bit binary port ID with a valid/ack handshake. Sits between the input-device request lines and the CPU input-port select logic.

Parameters:
N, 4, width of binary port ID
M, 16, number of request lines; M must equal 2**N (elaboration-time assertion)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  arbitration enable from CPU (same role as the decoder's load)
req  input  M  device request lines, rising-edge significant
ack  input  1  CPU accepts the presented ID
valid  output  1  id holds a granted request
id  output  N  binary index of the granted request line
pending  output  M  latched, not-yet-acknowledged requests
lost  output  1  one-cycle pulse: rising edge on a line that was already pending

Behaviour:
- Reset (synchronous, active-high):
  - valid=0, id=0, pending=0, lost=0, last_grant=M-1, state=IDLE.
  - req_q loads req, so lines held high through reset produce no edge.
  - Reset mid-presentation drops valid at that edge; all pending requests are discarded.
- Edge detect: rise = req & ~req_q; req_q <= req every cycle.
  - rise[i] sets pending[i] at the next edge.
  - If pending[i] is already 1, lost pulses 1 for one cycle; still one grant only.
- Round-robin selection (combinational):
  - Search pending starting at index (last_grant+1) mod M, ascending, wrapping at M-1 to 0.
  - The first set bit wins.
- State machine, two states:
  - IDLE: valid=0. If enable=1 and pending!=0, register winner into id, set valid=1, go to PRESENT. Otherwise stay.
  - PRESENT: id and valid held stable.
    - ack=1: clear pending[id], last_grant<=id, valid<=0, go to IDLE.
    - enable=0 (no ack): valid<=0, go to IDLE. pending and last_grant are unchanged (withdrawal).
    - ack and enable=0 in the same cycle: ack wins.
- Latency:
  - req rises before edge E0 -> pending set at E0 -> valid/id at E1 (enable=1, no other pending).
  - After ack at edge Ek, the next valid is at Ek+1. Maximum throughput is one grant per 2 cycles.
- Simultaneous events:
  - ack and a rise on the same line id: pending[id] stays 1 (set wins over clear). No lost pulse is generated. The line is re-arbitrated later.
  - ack while IDLE is ignored.
  - A rise on other lines during PRESENT is latched normally and does not disturb id.
- id keeps its last value while valid=0. Consumers qualify id with valid.

Decomposition:
- Package nibbler_io_pkg:
  - IO_ID_W=4 and IO_PORTS=16, shared with the port decoder.
  - Enum io_enc_state_t {IDLE, PRESENT}.
  - Typedefs io_id_t (logic [IO_ID_W-1:0]) and io_mask_t (logic [IO_PORTS-1:0]).
- Sub-module rr_priority_select: purely combinational.
  - Inputs: pending mask and last_grant.
  - Outputs: winner index and any flag.
  - Implementation: rotate, find-first, un-rotate. Reusable by other arbiters.

Test Plan:
1. Reset, then pulse req[5] one cycle with enable=1 -> valid=1, id=5 one edge after pending[5] sets. Ack -> valid=0 and pending=0 next edge.
2. After reset, req[3], req[9], req[12] rise together; ack each grant immediately -> grant order 3, 9, 12. Then req[14] and req[3] rise together -> 14 first, then 3 (wrap).
3. req[2] pending with enable=0 for 5 cycles -> valid stays 0. Raise enable -> valid=1, id=2 next edge. Drop enable while presenting with no ack -> valid=0, pending[2] still 1.
4. req[7] rises, falls, rises again before ack -> lost=1 for exactly one cycle; exactly one grant of id=7.
5. ack on id=4 in the same cycle req[4] rises -> pending[4] stays 1, lost=0, id=4 granted again later.
6. Assert reset while valid=1 with req[1] held high through release -> valid=0 and pending=0 after reset. No grant until req[1] falls and rises again.

Source files
------------

// File: rtl/nibbler_io_pkg.sv
// Shared definitions for the Nibbler I/O port decoder and request encoder.
package nibbler_io_pkg;

  localparam int IO_ID_W  = 4;
  localparam int IO_PORTS = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } io_enc_state_t;

  typedef logic [IO_ID_W-1:0]  io_id_t;
  typedef logic [IO_PORTS-1:0] io_mask_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin find-first: the search starts one above last_grant and wraps.
// Rotate the mask so the start index lands at bit 0, pick the lowest set
// bit, then add the start back. Relies on M == 2**N so index math wraps.
module rr_priority_select #(
  parameter int N = 4,
  parameter int M = 16
) (
  input  logic [M-1:0] pending,
  input  logic [N-1:0] last_grant,
  output logic [N-1:0] winner,
  output logic         any
);

  logic [N-1:0] w_start;
  logic [M-1:0] w_rot;
  logic [N-1:0] w_off;

  assign w_start = last_grant + {{(N-1){1'b0}}, 1'b1};

  // Rotate pending right by w_start.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < M; i++) begin
      w_rot[i] = pending[w_start + N'(i)];
    end
  end

  // Lowest set bit of the rotated mask; scanning downward leaves the lowest.
  always_comb begin
    w_off = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = N'(i);
    end
  end

  assign winner = w_start + w_off;
  assign any    = |pending;

endmodule

// File: rtl/io_request_encoder.sv
// Latches rising edges on device request lines as pending, arbitrates them
// round-robin and presents the winner to the CPU as a binary port ID with
// a valid/ack handshake.
//
// state   | meaning
// IDLE    | nothing presented; load winner when enabled and a request pends
// PRESENT | id/valid held until ack (grant consumed) or enable drop (withdrawn)
module io_request_encoder
  import nibbler_io_pkg::*;
#(
  parameter int N = IO_ID_W,
  parameter int M = IO_PORTS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [M-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [N-1:0] id,
  output logic [M-1:0] pending,
  output logic         lost
);

  if (M != (1 << N)) begin : g_bad_width
    $error("io_request_encoder: M must equal 2**N");
  end

  io_enc_state_t r_state, w_next_state;
  logic [M-1:0]  r_req_q;
  logic [M-1:0]  r_pending;
  logic [N-1:0]  r_last_grant;
  logic [N-1:0]  r_id;
  logic          r_lost;

  logic [M-1:0]  w_rise;
  logic [M-1:0]  w_clear;
  logic [N-1:0]  w_winner;
  logic          w_any;
  logic          w_load;
  logic          w_done;

  rr_priority_select #(.N(N), .M(M)) u_select (
    .pending    (r_pending),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any        (w_any)
  );

  assign w_rise  = req & ~r_req_q;
  assign w_clear = w_done ? ({{(M-1){1'b0}}, 1'b1} << r_id) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: ack takes priority over an enable drop while presenting.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (enable && w_any)  w_next_state = PRESENT;
      PRESENT: if (ack || !enable)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: valid and the load/consume strobes for the datapath.
  always_comb begin
    valid  = 1'b0;
    w_load = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE:    w_load = enable && w_any;
      PRESENT: begin
        valid  = 1'b1;
        w_done = ack;
      end
      default: ;
    endcase
  end

  // Edge capture, pending set/clear (set wins), grant bookkeeping.
  // A rise on the line being acked in the same cycle is not a lost request:
  // the clear is overridden and the line is simply re-arbitrated.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_q      <= req;
      r_pending    <= '0;
      r_last_grant <= '1;
      r_id         <= '0;
      r_lost       <= 1'b0;
    end else begin
      r_req_q   <= req;
      r_pending <= (r_pending & ~w_clear) | w_rise;
      r_lost    <= |(w_rise & r_pending & ~w_clear);
      if (w_load) r_id         <= w_winner;
      if (w_done) r_last_grant <= r_id;
    end
  end

  assign id      = r_id;
  assign pending = r_pending;
  assign lost    = r_lost;

endmodule

// File: tb/tb_io_request_encoder.sv
// Bench for io_request_encoder: a hand-derived vector table, directed
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_io_request_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] req;
  logic        ack;
  logic        valid;
  logic [3:0]  id;
  logic [15:0] pending;
  logic        lost;

  int errors = 0;
  int checks = 0;

  io_request_encoder #(.N(4), .M(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .ack     (ack),
    .valid   (valid),
    .id      (id),
    .pending (pending),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  bit        m_valid;
  int        m_id;
  int        m_last;
  bit        m_lost;
  bit [15:0] m_pend;
  bit [15:0] m_reqq;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit [15:0] rise;
    bit [15:0] clr;
    int        w;
    if (reset) begin
      m_valid = 0; m_id = 0; m_lost = 0; m_pend = '0; m_last = 15; m_reqq = req;
      return;
    end
    rise = req & ~m_reqq;
    clr  = '0;
    if (m_valid && ack) clr[m_id] = 1'b1;
    m_lost = ((rise & m_pend & ~clr) != 0);
    if (m_valid) begin
      if (ack) begin
        m_last  = m_id;
        m_valid = 0;
      end else if (!enable) begin
        m_valid = 0;
      end
    end else if (enable && m_pend != 0) begin
      w = -1;
      for (int k = 1; k <= 16 && w < 0; k++) begin
        if (m_pend[(m_last + k) % 16]) w = (m_last + k) % 16;
      end
      m_id    = w;
      m_valid = 1;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_reqq = req;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_valid",   valid,   m_valid);
    check("model_id",      id,      m_id);
    check("model_pending", pending, m_pend);
    check("model_lost",    lost,    m_lost);
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  typedef struct {
    bit        rst;
    bit        en;
    bit [15:0] rq;
    bit        ak;
    bit        ev;
    bit [3:0]  eid;
    bit [15:0] ep;
    bit        el;
  } vec_t;

  vec_t tbl[18];

  initial begin
    reset = 1; enable = 0; req = '0; ack = 0;

    //              rst en  req      ack  valid id  pending  lost
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 4'd0,  16'h0020, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 4'd5,  16'h0020, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd5,  16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h1208, 1'b0, 1'b0, 4'd0,  16'h1208, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h1208, 1'b0, 1'b1, 4'd3,  16'h1208, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h1208, 1'b1, 1'b0, 4'd3,  16'h1200, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h1208, 1'b0, 1'b1, 4'd9,  16'h1200, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h1208, 1'b1, 1'b0, 4'd9,  16'h1000, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h1208, 1'b0, 1'b1, 4'd12, 16'h1000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h1208, 1'b1, 1'b0, 4'd12, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd12, 16'h0000, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 16'h4008, 1'b0, 1'b0, 4'd12, 16'h4008, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 16'h4008, 1'b0, 1'b1, 4'd14, 16'h4008, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 16'h4008, 1'b1, 1'b0, 4'd14, 16'h0008, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 16'h4008, 1'b0, 1'b1, 4'd3,  16'h0008, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 16'h4008, 1'b1, 1'b0, 4'd3,  16'h0000, 1'b0};

    // Single grant, then ordering 3,9,12 and wrap 14 -> 3.
    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; req = tbl[i].rq; ack = tbl[i].ak;
      tick();
      check($sformatf("tbl%0d_valid", i),   valid,   tbl[i].ev);
      check($sformatf("tbl%0d_id", i),      id,      tbl[i].eid);
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].ep);
      check($sformatf("tbl%0d_lost", i),    lost,    tbl[i].el);
    end
    ack = 0; req = '0;

    // Pending held while disabled, then withdrawal on enable drop.
    enable = 0; do_reset();
    req = 16'h0004; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("disabled_valid", valid, 0);
    end
    enable = 1; tick();
    check("enable_valid", valid, 1);
    check("enable_id", id, 2);
    enable = 0; tick();
    check("withdraw_valid", valid, 0);
    check("withdraw_pending", pending, 16'h0004);
    enable = 1; tick();
    check("regrant_id", id, 2);
    ack = 1; tick(); ack = 0;
    check("regrant_clear", pending, 0);

    // Second rise before ack: one lost pulse, one grant.
    req = '0; do_reset();
    req = 16'h0080; tick();
    tick();
    check("lost_grant_id", id, 7);
    req = '0; tick();
    req = 16'h0080; tick();
    check("lost_pulse", lost, 1);
    tick();
    check("lost_one_cycle", lost, 0);
    check("lost_still_valid", valid, 1);
    ack = 1; tick(); ack = 0;
    check("lost_ack_pending", pending, 0);
    tick();
    check("lost_single_grant", valid, 0);

    // Ack coincides with a rise on the granted line.
    req = '0; do_reset();
    req = 16'h0010; tick();
    req = '0; tick();
    check("coinc_grant", id, 4);
    req = 16'h0010; ack = 1; tick(); ack = 0;
    check("coinc_pending", pending, 16'h0010);
    check("coinc_lost", lost, 0);
    check("coinc_valid", valid, 0);
    tick();
    check("coinc_regrant_valid", valid, 1);
    check("coinc_regrant_id", id, 4);
    ack = 1; tick(); ack = 0;

    // Reset during presentation with the request held through release.
    req = '0; do_reset();
    req = 16'h0002; tick();
    tick();
    check("pre_reset_valid", valid, 1);
    reset = 1; tick(); reset = 0;
    check("reset_valid", valid, 0);
    check("reset_pending", pending, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_grant", valid, 0);
    end
    req = '0; tick();
    req = 16'h0002; tick();
    tick();
    check("post_reset_grant_valid", valid, 1);
    check("post_reset_grant_id", id, 1);

    // Random traffic checked against the model each cycle.
    req = '0; ack = 0; do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      end
      enable = ($urandom_range(0, 7) != 0);
      ack    = ($urandom_range(0, 2) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
